// File: rtl/hazard_scoreboard_ctrl.sv
// Decode-stage sequencer: per-register pending-write scoreboard with RAW/WAW stall and a taken-branch flush FSM.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined; otherwise they read 0.
//
// Handshake: decode presents an instruction with id_valid; it transfers into ID/EX in exactly the
// cycle where issue=1 (issue implies id_valid). When id_valid=1 and issue=0, decode must hold the
// same instruction (stall) or it is discarded by a flush.
module hazard_scoreboard_ctrl #(
  parameter int NREG         = 16,
  parameter int IDX_W        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int WB_BYPASS    = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [IDX_W-1:0] id_ra,
  input  logic [IDX_W-1:0] id_rb,
  input  logic [IDX_W-1:0] id_rd,
  input  logic             id_use_ra,
  input  logic             id_use_rb,
  input  logic             id_wr_rd,
  input  logic             wb_we,
  input  logic [IDX_W-1:0] wb_rd,
  input  logic             br_taken,
  output logic             issue,
  output logic             stall,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [NREG-1:0]  pending,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  // Cycles remaining in FLUSH after the br_taken cycle, minus one.
  localparam logic [3:0] FCNT_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  state_t          state_q;
  logic [3:0]      fcnt_q;
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] eff_pend;
  logic            hazard;
  logic            flushing;

  assign wb_mask  = wb_we ? (NREG'(1) << wb_rd) : '0;
  assign eff_pend = (WB_BYPASS != 0) ? (pending_q & ~wb_mask) : pending_q;

  assign hazard = id_valid & ((id_use_ra & eff_pend[id_ra]) |
                              (id_use_rb & eff_pend[id_rb]) |
                              (id_wr_rd  & eff_pend[id_rd]));

  assign flushing = br_taken | (state_q == S_FLUSH);

  // Combinational controls are forced low while reset is held, independent of the inputs.
  assign stall      = ~rst & hazard & ~flushing;
  assign issue      = ~rst & id_valid & ~hazard & ~flushing;
  assign flush_ifid = ~rst & flushing;
  assign flush_idex = ~rst & (flushing | hazard);
  assign busy       = (state_q == S_FLUSH);
  assign pending    = pending_q;

  // Writeback clear first, then issue set, so a same-index set wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_we) begin
      pending_d[wb_rd] = 1'b0;
    end
    if (issue && id_wr_rd) begin
      pending_d[id_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (br_taken && (FLUSH_CYCLES > 1)) begin
            state_q <= S_FLUSH;
            fcnt_q  <= FCNT_INIT;
          end
        end
        S_FLUSH: begin
          // br_taken here is ignored: EX only holds bubbles during a flush.
          if (fcnt_q == 4'd0) begin
            state_q <= S_IDLE;
          end else begin
            fcnt_q <= fcnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          fcnt_q  <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (br_taken && (state_q == S_IDLE) && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Bench for hazard_scoreboard_ctrl: directed scenarios then random traffic against a register-array reference model.
module tb_hazard_scoreboard_ctrl;

  localparam int NREG         = 16;
  localparam int IDX_W        = 4;
  localparam int FLUSH_CYCLES = 2;
  localparam int WB_BYPASS    = 1;
  localparam int CNT_W        = 32;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             id_valid;
  logic [IDX_W-1:0] id_ra, id_rb, id_rd;
  logic             id_use_ra, id_use_rb, id_wr_rd;
  logic             wb_we;
  logic [IDX_W-1:0] wb_rd;
  logic             br_taken;
  logic             issue, stall, flush_ifid, flush_idex, busy;
  logic [NREG-1:0]  pending;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard_ctrl #(
    .NREG(NREG), .IDX_W(IDX_W), .FLUSH_CYCLES(FLUSH_CYCLES),
    .WB_BYPASS(WB_BYPASS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb), .id_rd(id_rd),
    .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .id_wr_rd(id_wr_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .br_taken(br_taken),
    .issue(issue), .stall(stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .pending(pending), .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // ---------------- reference model ----------------
  // Each register is simply "has an outstanding write or not"; a flush is a count of
  // remaining extra flush cycles after the branch cycle.
  int          total = 0;
  int          bad   = 0;
  bit          reg_busy_m[NREG];
  int          flush_left;
  longint      stalls_m;
  longint      flushes_m;
  logic [NREG-1:0] exp_q[$];

  function automatic logic [NREG-1:0] model_pending();
    logic [NREG-1:0] p;
    for (int i = 0; i < NREG; i++) p[i] = reg_busy_m[i];
    return p;
  endfunction

  function automatic bit model_busy_for_decode(input int r);
    bit cleared_now;
    cleared_now = (WB_BYPASS != 0) && wb_we && (int'(wb_rd) == r);
    return reg_busy_m[r] && !cleared_now;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) reg_busy_m[i] = 1'b0;
    flush_left = 0;
    stalls_m   = 0;
    flushes_m  = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    id_valid = 0; id_ra = '0; id_rb = '0; id_rd = '0;
    id_use_ra = 0; id_use_rb = 0; id_wr_rd = 0;
    wb_we = 0; wb_rd = '0; br_taken = 0;
  endtask

  task automatic set_id(input bit v, input int ra, input int rb, input int rd,
                        input bit ura, input bit urb, input bit wr);
    id_valid = v; id_ra = IDX_W'(ra); id_rb = IDX_W'(rb); id_rd = IDX_W'(rd);
    id_use_ra = ura; id_use_rb = urb; id_wr_rd = wr;
  endtask

  task automatic set_wb(input bit we, input int rd);
    wb_we = we; wb_rd = IDX_W'(rd);
  endtask

  // Check all outputs mid-cycle against the model, then advance the model across the edge.
  task automatic step(input string tag);
    bit hz, fl, e_stall, e_issue;
    @(negedge clk);
    hz = id_valid && ((id_use_ra && model_busy_for_decode(int'(id_ra))) ||
                      (id_use_rb && model_busy_for_decode(int'(id_rb))) ||
                      (id_wr_rd  && model_busy_for_decode(int'(id_rd))));
    fl = br_taken || (flush_left > 0);
    e_stall = hz && !fl;
    e_issue = id_valid && !hz && !fl;
    exp_q.push_back(model_pending());
    chk({tag, ".issue"},      64'(issue),      64'(e_issue));
    chk({tag, ".stall"},      64'(stall),      64'(e_stall));
    chk({tag, ".flush_ifid"}, 64'(flush_ifid), 64'(fl));
    chk({tag, ".flush_idex"}, 64'(flush_idex), 64'(fl || hz));
    chk({tag, ".busy"},       64'(busy),       64'(flush_left > 0));
    chk({tag, ".pending"},    64'(pending),    64'(exp_q.pop_front()));
    chk({tag, ".stall_cnt"},  64'(stall_cnt),  STATS ? 64'(stalls_m)  : 64'd0);
    chk({tag, ".flush_cnt"},  64'(flush_cnt),  STATS ? 64'(flushes_m) : 64'd0);
    @(posedge clk);
    if (wb_we) reg_busy_m[int'(wb_rd)] = 1'b0;
    if (e_issue && id_wr_rd) reg_busy_m[int'(id_rd)] = 1'b1;
    if (e_stall && stalls_m < 64'hFFFF_FFFF) stalls_m++;
    if (br_taken && flush_left == 0 && flushes_m < 64'hFFFF_FFFF) flushes_m++;
    if (flush_left > 0) flush_left--;
    else if (br_taken) flush_left = FLUSH_CYCLES - 1;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    model_clear();
    chk("rst.pending", 64'(pending), 64'd0);
    chk("rst.busy",    64'(busy),    64'd0);
    chk("rst.issue",   64'(issue),   64'd0);
    rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    idle_inputs();
    model_clear();
    do_reset();

    // RAW stall on r3 released by writeback of r3.
    set_id(1, 0, 0, 3, 0, 0, 1);                 step("raw_issue_wr_r3");
    set_id(1, 3, 0, 4, 1, 0, 1);                 step("raw_stall_a");
    chk("raw.stall_direct", 64'(pending[3]), 64'd1);
                                                 step("raw_stall_b");
    set_wb(1, 3);                                step("raw_release");
    set_wb(0, 0); set_id(0, 0, 0, 0, 0, 0, 0);   step("raw_idle");
    set_wb(1, 4);                                step("raw_drain_r4");
    set_wb(0, 0);

    // Taken branch; a second br_taken pulse mid-flush must not extend it.
    set_id(1, 1, 2, 6, 1, 1, 1); br_taken = 1;   step("br_cycle1");
    chk("br.busy_after_edge", 64'(busy), 64'd1);
                                                 step("br_cycle2_repulse");
    br_taken = 0;                                step("br_after");
    chk("br.busy_clear", 64'(busy), 64'd0);
    set_id(0, 0, 0, 0, 0, 0, 0);                 step("br_idle");

    // Same-cycle writeback and re-issue of r5; older stall on r5 released.
    set_id(1, 0, 0, 5, 0, 0, 1);                 step("waw_issue_r5");
    set_id(1, 5, 0, 5, 1, 0, 1);                 step("waw_stall_r5");
    set_wb(1, 5);                                step("waw_wb_and_issue_r5");
    set_wb(0, 0); set_id(0, 0, 0, 0, 0, 0, 0);
    chk("waw.pending5_set", 64'(pending[5]), 64'd1);
                                                 step("waw_idle");

    // Rb not used: pending r7 must not stall.
    set_id(1, 0, 0, 7, 0, 0, 1);                 step("imm_issue_r7");
    set_id(1, 1, 7, 2, 1, 0, 0);                 step("imm_no_stall");
    chk("imm.issue_direct_prev", 64'(pending[7]), 64'd1);

    // Async reset mid-flush with pending = 16'h00F0.
    do_reset();
    for (int r = 4; r < 8; r++) begin
      set_id(1, 0, 0, r, 0, 0, 1);               step("mid_setup");
    end
    set_id(0, 0, 0, 0, 0, 0, 0);
    chk("mid.pending_setup", 64'(pending), 64'h00F0);
    br_taken = 1;                                step("mid_br");
    chk("mid.busy_setup", 64'(busy), 64'd1);
    set_id(1, 4, 5, 6, 1, 1, 1);
    rst = 1'b1;
    #1;
    chk("mid.pending", 64'(pending),    64'd0);
    chk("mid.busy",    64'(busy),       64'd0);
    chk("mid.issue",   64'(issue),      64'd0);
    chk("mid.stall",   64'(stall),      64'd0);
    chk("mid.ifid",    64'(flush_ifid), 64'd0);
    chk("mid.idex",    64'(flush_idex), 64'd0);
    do_reset();

    // Statistics: 3 hazard-stall cycles and one taken branch.
    set_id(1, 0, 0, 9, 0, 0, 1);                 step("st_issue_r9");
    set_id(1, 9, 0, 1, 1, 0, 0);                 step("st_stall1");
                                                 step("st_stall2");
                                                 step("st_stall3");
    set_wb(1, 9);                                step("st_release");
    set_wb(0, 0); set_id(0, 0, 0, 0, 0, 0, 0);
    br_taken = 1;                                step("st_br");
    br_taken = 0;                                step("st_flush2");
                                                 step("st_idle");
    chk("st.stall_cnt", 64'(stall_cnt), STATS ? 64'd3 : 64'd0);
    chk("st.flush_cnt", 64'(flush_cnt), STATS ? 64'd1 : 64'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
             $urandom_range(0, NREG - 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1));
      set_wb($urandom_range(0, 1), $urandom_range(0, NREG - 1));
      br_taken = ($urandom_range(0, 7) == 0);
      step("rnd");
    end
    idle_inputs();
    step("rnd_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
